// File: rtl/gs_pkg.sv
// Shared types for the GS load/store unit.
//   - DataSize codes carried on ex_DataSize_i (size in bits [1:0], bit 2 = unsigned)
//   - FSM state enum of the LSU control path
//   - is_misaligned(): alignment rule shared by capture logic
package gs_pkg;

   localparam logic [2:0] DS_B  = 3'b000;  // LB / SB
   localparam logic [2:0] DS_H  = 3'b001;  // LH / SH
   localparam logic [2:0] DS_W  = 3'b010;  // LW / SW
   localparam logic [2:0] DS_BU = 3'b100;  // LBU
   localparam logic [2:0] DS_HU = 3'b101;  // LHU

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_e;

   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
      logic mis;
      case (size[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/gs_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Handshake: the master raises dm_req_o with we/be/addr/wdata and keeps all
// of them stable until the cycle in which dm_gnt_i is sampled high; that
// cycle transfers the request. Read data returns later as a single-cycle
// dm_rvalid_i pulse with dm_rdata_i; there is no back-pressure on the return.
// Signal names carry the LSU's point of view (_o driven by the master).
interface gs_lsu_if #(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32
);
   logic                 dm_req_o;
   logic                 dm_we_o;
   logic [3:0]           dm_be_o;
   logic [ADDR_SIZE-1:0] dm_addr_o;
   logic [WORD_SIZE-1:0] dm_wdata_o;
   logic                 dm_gnt_i;
   logic                 dm_rvalid_i;
   logic [WORD_SIZE-1:0] dm_rdata_i;

   modport master (
      output dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o,
      input  dm_gnt_i, dm_rvalid_i, dm_rdata_i
   );

   modport slave (
      input  dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o,
      output dm_gnt_i, dm_rvalid_i, dm_rdata_i
   );
endinterface

// File: rtl/gs_lsu_align.sv
// Load alignment: shifts the addressed lane down to bit 0, then sign- or
// zero-extends according to the DataSize code.
//   rdata_i  : raw 32-bit word from memory
//   offset_i : byte offset addr[1:0] of the access
//   size_i   : DataSize code (gs_pkg DS_*)
//   data_o   : value to write back to the register file
module gs_lsu_align
   import gs_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  size_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      case (size_i)
         DS_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
         DS_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
         DS_BU:   data_o = {24'b0, shifted[7:0]};
         DS_HU:   data_o = {16'b0, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/gs_lsu.sv
// GS load/store unit. Takes one EX-stage memory command at a time, issues it
// on the data-memory bus and writes load results back to the register file.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   ex_*_i            : EX-stage command (valid, read/write, size, addr, data, rd)
//   dm                : data-memory bus (gs_lsu_if master)
//   wb_*_o            : one-cycle load write-back
//   halt_lsu_o        : stalls upstream while a transaction is outstanding
//   lsu_misaligned_o  : one-cycle pulse after a rejected misaligned command
//   dbg_state_o       : current FSM state
module gs_lsu
   import gs_pkg::*;
#(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid_i,
   input  logic                 ex_MemRead_i,
   input  logic                 ex_MemWrite_i,
   input  logic [2:0]           ex_DataSize_i,
   input  logic [ADDR_SIZE-1:0] ex_data_addr_i,
   input  logic [WORD_SIZE-1:0] ex_rs2_data_i,
   input  logic [4:0]           ex_rd_addr_i,
   input  logic                 ex_RegWrite_i,
   gs_lsu_if.master             dm,
   output logic                 wb_RegWrite_o,
   output logic [4:0]           wb_rd_addr_o,
   output logic [WORD_SIZE-1:0] wb_rd_data_o,
   output logic                 halt_lsu_o,
   output logic                 lsu_misaligned_o,
   output lsu_state_e           dbg_state_o
);

   lsu_state_e           state_q, state_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [3:0]           be_q, be_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [2:0]           size_q, size_d;
   logic [4:0]           rd_q, rd_d;
   logic                 regwr_q, regwr_d;
   logic                 we_q, we_d;
   logic                 wb_we_q, wb_we_d;
   logic [4:0]           wb_rd_q, wb_rd_d;
   logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
   logic                 mis_q, mis_d;
   logic [WORD_SIZE-1:0] load_data;
   logic                 cmd;

   gs_lsu_align u_align (
      .rdata_i  (dm.dm_rdata_i),
      .offset_i (addr_q[1:0]),
      .size_i   (size_q),
      .data_o   (load_data)
   );

   assign cmd = ex_valid_i & (ex_MemRead_i | ex_MemWrite_i);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      rd_d       = rd_q;
      regwr_d    = regwr_q;
      we_d       = we_q;
      wb_we_d    = 1'b0;
      wb_rd_d    = 5'd0;
      wb_data_d  = '0;
      mis_d      = 1'b0;
      halt_lsu_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd) begin
               if (is_misaligned(ex_DataSize_i, ex_data_addr_i[1:0])) begin
                  mis_d = 1'b1;
               end else begin
                  addr_d  = ex_data_addr_i;
                  size_d  = ex_DataSize_i;
                  rd_d    = ex_rd_addr_i;
                  regwr_d = ex_RegWrite_i;
                  // Read wins when both request bits are set.
                  we_d    = ex_MemWrite_i & ~ex_MemRead_i;
                  case (ex_DataSize_i[1:0])
                     2'b00: begin
                        be_d    = 4'b0001 << ex_data_addr_i[1:0];
                        wdata_d = {4{ex_rs2_data_i[7:0]}};
                     end
                     2'b01: begin
                        be_d    = 4'b0011 << {ex_data_addr_i[1], 1'b0};
                        wdata_d = {2{ex_rs2_data_i[15:0]}};
                     end
                     default: begin
                        be_d    = 4'b1111;
                        wdata_d = ex_rs2_data_i;
                     end
                  endcase
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // A store completes on its grant, so the stall drops in that cycle.
            halt_lsu_o = ~(dm.dm_gnt_i & we_q);
            if (dm.dm_gnt_i) begin
               state_d = we_q ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            halt_lsu_o = ~dm.dm_rvalid_i;
            if (dm.dm_rvalid_i) begin
               wb_we_d   = regwr_q & (rd_q != 5'd0);
               wb_rd_d   = rd_q;
               wb_data_d = load_data;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         be_q      <= 4'b0;
         wdata_q   <= '0;
         size_q    <= 3'b0;
         rd_q      <= 5'd0;
         regwr_q   <= 1'b0;
         we_q      <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_rd_q   <= 5'd0;
         wb_data_q <= '0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         rd_q      <= rd_d;
         regwr_q   <= regwr_d;
         we_q      <= we_d;
         wb_we_q   <= wb_we_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         mis_q     <= mis_d;
      end
   end

   assign dm.dm_req_o   = (state_q == ST_REQ);
   assign dm.dm_we_o    = we_q;
   assign dm.dm_be_o    = be_q;
   assign dm.dm_addr_o  = {addr_q[ADDR_SIZE-1:2], 2'b00};
   assign dm.dm_wdata_o = wdata_q;

   assign wb_RegWrite_o    = wb_we_q;
   assign wb_rd_addr_o     = wb_rd_q;
   assign wb_rd_data_o     = wb_data_q;
   assign lsu_misaligned_o = mis_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_gs_lsu.sv
module tb_gs_lsu;
   import gs_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        ex_valid, ex_rd, ex_wr, ex_rw;
   logic [2:0]  ex_size;
   logic [31:0] ex_addr, ex_data;
   logic [4:0]  ex_rdaddr;
   logic        wb_we, halt, mis;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   lsu_state_e  dbg_state;

   gs_lsu_if #(.ADDR_SIZE(32), .WORD_SIZE(32)) dm_if ();

   gs_lsu dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid_i       (ex_valid),
      .ex_MemRead_i     (ex_rd),
      .ex_MemWrite_i    (ex_wr),
      .ex_DataSize_i    (ex_size),
      .ex_data_addr_i   (ex_addr),
      .ex_rs2_data_i    (ex_data),
      .ex_rd_addr_i     (ex_rdaddr),
      .ex_RegWrite_i    (ex_rw),
      .dm               (dm_if),
      .wb_RegWrite_o    (wb_we),
      .wb_rd_addr_o     (wb_rd),
      .wb_rd_data_o     (wb_data),
      .halt_lsu_o       (halt),
      .lsu_misaligned_o (mis),
      .dbg_state_o      (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_fail = 0;
   logic [69:0] req_q[$];   // {check_wdata, we, be, addr, wdata}
   logic [36:0] exp_q[$];   // {rd, data}
   int mis_pending = 0;

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] size);
      return (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic m_mis(input logic [2:0] size, input logic [31:0] addr);
      return (int'(addr[1:0]) % nbytes(size)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
      logic [3:0] be;
      int off = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(size));
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
      logic [31:0] w;
      int nb = nbytes(size);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      int off = int'(addr[1:0]);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rdata[8*off +: 8];
      h = (off == 2) ? rdata[31:16] : rdata[15:0];
      case (size)
         DS_B:    r = (b[7]  ? 32'hFFFF_FF00 : 32'h0) | {24'h0, b};
         DS_H:    r = (h[15] ? 32'hFFFF_0000 : 32'h0) | {16'h0, h};
         DS_BU:   r = {24'h0, b};
         DS_HU:   r = {16'h0, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (dm_if.dm_req_o) begin
         if (req_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_req: got addr %h with nothing expected", dm_if.dm_addr_o);
         end else begin
            chk("dm_req", {req_q[0][69], dm_if.dm_we_o, dm_if.dm_be_o, dm_if.dm_addr_o,
                           req_q[0][69] ? dm_if.dm_wdata_o : req_q[0][31:0]}, req_q[0]);
            if (dm_if.dm_gnt_i) void'(req_q.pop_front());
         end
      end
      if (wb_we) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_wb: got rd %0d data %h with nothing expected", wb_rd, wb_data);
         end else begin
            chk("wb", {wb_rd, wb_data}, exp_q.pop_front());
         end
      end
      if (mis) begin
         n_cmp++;
         if (mis_pending == 0) begin
            n_fail++;
            $display("FAIL unexpected_mis: got pulse expected none at %0t", $time);
         end else begin
            mis_pending--;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input logic rdn, input logic wrn, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic rw,
                          input int gdly, input int rdly, input logic [31:0] rdata);
      logic load = rdn;
      logic bad  = m_mis(size, addr);
      tick();
      ex_valid = 1'b1; ex_rd = rdn; ex_wr = wrn; ex_size = size;
      ex_addr = addr; ex_data = data; ex_rdaddr = rd; ex_rw = rw;
      if (bad) begin
         mis_pending++;
      end else begin
         req_q.push_back({~load, ~load, m_be(size, addr), {addr[31:2], 2'b00},
                          load ? 32'h0 : m_wdata(size, data)});
         if (load && rw && rd != 5'd0) exp_q.push_back({rd, m_load(size, addr, rdata)});
      end
      tick();
      // Junk on the EX bus must not disturb the captured command.
      ex_valid = 1'b0; ex_addr = $urandom; ex_data = $urandom;
      ex_rdaddr = 5'($urandom); ex_size = 3'($urandom);
      if (bad) begin
         @(negedge clk); chk("mis_pulse", {halt, mis, dm_if.dm_req_o}, 3'b010);
         tick();
         @(negedge clk); chk("mis_clear", {halt, mis, dm_if.dm_req_o}, 3'b000);
         return;
      end
      for (int g = 0; g < gdly; g++) begin
         @(negedge clk); chk("halt_req", {halt, dm_if.dm_req_o}, 2'b11);
         tick();
      end
      dm_if.dm_gnt_i = 1'b1;
      @(negedge clk); chk("halt_gnt", {halt, dm_if.dm_req_o}, {load, 1'b1});
      tick();
      dm_if.dm_gnt_i = 1'b0;
      if (!load) begin
         @(negedge clk); chk("idle_after_st", {halt, dm_if.dm_req_o, dbg_state}, {2'b00, ST_IDLE});
         return;
      end
      for (int r = 0; r < rdly; r++) begin
         @(negedge clk); chk("halt_wait", {halt, dm_if.dm_req_o}, 2'b10);
         tick();
      end
      dm_if.dm_rvalid_i = 1'b1; dm_if.dm_rdata_i = rdata;
      @(negedge clk); chk("halt_rvalid", halt, 1'b0);
      tick();
      dm_if.dm_rvalid_i = 1'b0; dm_if.dm_rdata_i = $urandom;
      @(negedge clk); chk("wb_pulse", wb_we, rw && rd != 5'd0);
      tick();
      @(negedge clk); chk("wb_one_cycle", wb_we, 1'b0);
   endtask

   task automatic idle_gap();
      int n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         tick();
         // Stray return data while idle must be ignored.
         dm_if.dm_rvalid_i = ($urandom_range(0, 3) == 0);
         dm_if.dm_rdata_i  = $urandom;
      end
      tick();
      dm_if.dm_rvalid_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_dm"}, {dm_if.dm_req_o, dm_if.dm_we_o, dm_if.dm_be_o, dm_if.dm_addr_o,
                          dm_if.dm_wdata_o}, '0);
      chk({name, "_wb"}, {wb_we, wb_rd, wb_data}, '0);
      chk({name, "_ctl"}, {halt, mis, dbg_state}, {2'b00, ST_IDLE});
   endtask

   // ---------------- stimulus ----------------
   logic [2:0] sizes[5] = '{DS_B, DS_H, DS_W, DS_BU, DS_HU};

   initial begin
      ex_valid = 0; ex_rd = 0; ex_wr = 0; ex_rw = 0; ex_size = 0;
      ex_addr = 0; ex_data = 0; ex_rdaddr = 0;
      dm_if.dm_gnt_i = 0; dm_if.dm_rvalid_i = 0; dm_if.dm_rdata_i = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); chk_all_zero("reset");
      tick();
      rst = 1'b1;

      // Directed cases
      run_cmd(0, 1, DS_W, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 2, 0, 0);          // SW, late grant
      run_cmd(0, 1, DS_B, 32'h103, 32'h0000_00A5, 5'd0, 0, 0, 0, 0);          // SB lane 3
      run_cmd(1, 0, DS_B, 32'h102, 0, 5'd5, 1, 0, 0, 32'h0080_FF00);          // LB sign
      run_cmd(1, 0, DS_BU, 32'h102, 0, 5'd6, 1, 1, 2, 32'h0080_FF00);         // LBU zero
      run_cmd(1, 0, DS_H, 32'h101, 0, 5'd7, 1, 0, 0, 32'h1234_5678);          // LH misaligned
      run_cmd(1, 0, DS_W, 32'h200, 0, 5'd0, 1, 0, 0, 32'hCAFE_F00D);          // LW rd=0
      run_cmd(1, 1, DS_HU, 32'h302, 32'hFFFF_FFFF, 5'd9, 1, 0, 1, 32'h8001_7FFF); // both -> load

      // Reset while waiting for read data, then a late rvalid
      tick();
      ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_size = DS_W; ex_addr = 32'h400; ex_rdaddr = 5'd3; ex_rw = 1;
      req_q.push_back({1'b0, 1'b0, 4'b1111, 32'h400, 32'h0});
      tick();
      ex_valid = 0;
      dm_if.dm_gnt_i = 1'b1;
      tick();
      dm_if.dm_gnt_i = 1'b0;
      @(negedge clk); chk("in_wait", dbg_state, ST_WAIT);
      #2 rst = 1'b0;
      #1 chk_all_zero("rst_wait");
      tick();
      rst = 1'b1;
      dm_if.dm_rvalid_i = 1'b1; dm_if.dm_rdata_i = 32'h5555_AAAA;
      tick();
      dm_if.dm_rvalid_i = 1'b0;
      @(negedge clk); chk("late_rvalid", {wb_we, halt, dbg_state}, {2'b00, ST_IDLE});

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         int kind = $urandom_range(0, 2);
         logic [2:0] sz = (kind == 1) ? sizes[$urandom_range(0, 2)] : sizes[$urandom_range(0, 4)];
         logic [31:0] a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & 2'(~(nbytes(sz) - 1));
         run_cmd(kind != 1, kind != 0, sz, a, $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         idle_gap();
      end

      repeat (3) tick();
      chk("queues_empty", {req_q.size(), exp_q.size(), mis_pending}, '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gs_lsu.md
GS_LSU -- requirements
Module: GS_LSU

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, 32, address width; WORD_SIZE, 32, data width.
REQ-002 clk input 1 SHALL be the single clock; rst input 1 SHALL be the asynchronous, active-low reset.
REQ-003 ex_valid_i input 1 SHALL qualify the EX-stage memory command.
REQ-004 ex_MemRead_i, ex_MemWrite_i input 1 each SHALL be the load and store requests.
REQ-005 ex_DataSize_i input 3 SHALL be the access size/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-006 ex_data_addr_i input 32 SHALL be the byte address; ex_rs2_data_i input 32 SHALL be the store data.
REQ-007 ex_rd_addr_i input 5 and ex_RegWrite_i input 1 SHALL be the load destination and its write enable.
REQ-008 dm_req_o output 1, dm_we_o output 1, dm_be_o output 4, dm_addr_o output 32 (word aligned) and dm_wdata_o output 32 SHALL form the data-memory request.
REQ-009 dm_gnt_i input 1 SHALL accept the request; dm_rvalid_i input 1 with dm_rdata_i input 32 SHALL return read data.
REQ-010 wb_RegWrite_o output 1, wb_rd_addr_o output 5 and wb_rd_data_o output 32 SHALL be the load write-back to the register file.
REQ-011 halt_lsu_o output 1 SHALL stall the upstream pipeline; lsu_misaligned_o output 1 SHALL flag a misaligned access.

Function
REQ-012 FSM states SHALL be IDLE, REQ and WAIT.
REQ-013 In IDLE, ex_valid_i & (ex_MemRead_i | ex_MemWrite_i) SHALL capture addr, data, size, rd and RegWrite at the clock edge; the next state SHALL be REQ.
REQ-014 If MemRead and MemWrite are both high, the access SHALL be treated as a load.
REQ-015 A misaligned capture (half with addr[0]=1, or word with addr[1:0]!=0) SHALL stay in IDLE, pulse lsu_misaligned_o for the following cycle, and issue no dm_req_o or write-back.
REQ-016 In REQ, dm_req_o SHALL be 1 and the request fields SHALL be held stable until the cycle in which dm_gnt_i=1.
REQ-017 A store grant SHALL return the FSM to IDLE; a load grant SHALL move it to WAIT.
REQ-018 In WAIT, dm_rvalid_i SHALL register the extracted data on wb_* for exactly one cycle and return the FSM to IDLE; rvalid outside WAIT SHALL be ignored.
REQ-019 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-020 dm_wdata_o SHALL replicate the byte (x4) or half (x2) across lanes; a word store SHALL pass through unchanged.
REQ-021 Load data SHALL be dm_rdata_i>>(8*addr[1:0]), then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-022 wb_RegWrite_o SHALL be forced to 0 when rd=0 or the captured RegWrite=0.
REQ-023 halt_lsu_o SHALL be 1 in REQ and WAIT, and SHALL be 0 in the completing cycle (store grant or load rvalid) and in IDLE.
REQ-024 A new command SHALL be captured only in IDLE; commands presented while halted SHALL be held upstream.
REQ-025 Minimum latency SHALL be: store, 1 cycle after capture; load, wb_* valid 3 cycles after capture when gnt and rvalid arrive at the earliest.

Reset
REQ-026 Asserting rst low SHALL force IDLE and clear all outputs and captured registers to 0 asynchronously, including mid-transaction.
REQ-027 Any outstanding rvalid after reset SHALL be ignored.

Structure
REQ-028 The DataSize codes and the FSM state enum SHALL live in gs_pkg.
REQ-029 Load alignment and extension SHALL be a combinational sub-module GS_LSU_ALIGN.

Verification
REQ-030 SW addr 0x100, data 0xDEADBEEF, gnt delayed 2 cycles -> be=1111, wdata=0xDEADBEEF held for 3 REQ cycles, halt_lsu_o high until the grant cycle.
REQ-031 SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
REQ-032 LB addr 0x102, rdata 0x0080FF00 -> wb_rd_data_o=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-033 LH addr 0x101 -> lsu_misaligned_o pulses 1 cycle, no dm_req_o, no write-back.
REQ-034 LW to rd=0 -> memory read occurs and wb_RegWrite_o stays 0.
REQ-035 rst asserted in WAIT, then a late rvalid -> FSM in IDLE, all outputs 0, no write-back.
